// File: rtl/tl_d_resp_fifo.sv
// TileLink-UL D-channel responder: buffers MPU completion records, maps the
// originating A opcode to a D opcode and presents single-beat D responses
// from a registered output stage that holds steady under backpressure.
module tl_d_resp_fifo #(
  parameter int FIFO_DEPTH = 6,
  parameter int DATA_W     = 32,
  parameter int SRC_W      = 4,
  parameter int SINK_ID    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              resp_push,
  input  logic [2:0]        resp_opcode,
  input  logic [2:0]        resp_size,
  input  logic [SRC_W-1:0]  resp_source,
  input  logic              resp_denied,
  input  logic [DATA_W-1:0] resp_data,
  output logic              resp_rdy,
  output logic              d_valid,
  input  logic              d_ready,
  output logic [2:0]        d_opcode,
  output logic [1:0]        d_param,
  output logic [2:0]        d_size,
  output logic [SRC_W-1:0]  d_source,
  output logic              d_sink,
  output logic              d_denied,
  output logic              d_corrupt,
  output logic [DATA_W-1:0] d_data,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // Output-stage states
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        size;
    logic [SRC_W-1:0]  source;
    logic              denied;
    logic              corrupt;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t             storage_q [FIFO_DEPTH];
  rec_t             storage_d [FIFO_DEPTH];
  rec_t             out_q, out_d;
  rec_t             push_rec;
  logic [0:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             push_acc, fire, fifo_empty, pop, wr_en;

  // Translate the A opcode into the D response record at push time
  always_comb begin
    push_rec        = '0;
    push_rec.size   = resp_size;
    push_rec.source = resp_source;
    case (resp_opcode)
      3'd4: begin
        push_rec.opcode  = 3'd1;
        push_rec.denied  = resp_denied;
        push_rec.corrupt = resp_denied;
        push_rec.data    = resp_denied ? '0 : resp_data;
      end
      3'd0, 3'd1: begin
        push_rec.opcode = 3'd0;
        push_rec.denied = resp_denied;
      end
      default: begin
        push_rec.opcode = 3'd0;
        push_rec.denied = 1'b1;
      end
    endcase
  end

  // Handshake decode, output-stage FSM, FIFO bookkeeping and error counter
  always_comb begin
    push_acc   = resp_push && resp_rdy;
    fire       = (state_q == ST_HOLD) && d_ready;
    fifo_empty = (count_q == '0);
    pop        = fire && !fifo_empty;
    // A push bypasses storage when the output stage is (or is becoming) free
    wr_en      = push_acc && (state_q == ST_HOLD) && !(fire && fifo_empty);

    state_d     = state_q;
    out_d       = out_q;
    storage_d   = storage_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_count_d = err_count_q;

    if (state_q == ST_EMPTY) begin
      if (push_acc) begin
        out_d   = push_rec;
        state_d = ST_HOLD;
      end
    end else if (fire) begin
      if (!fifo_empty) begin
        out_d = storage_q[rd_ptr_q];
      end else if (push_acc) begin
        out_d = push_rec;
      end else begin
        out_d   = '0;
        state_d = ST_EMPTY;
      end
    end

    if (wr_en) begin
      storage_d[wr_ptr_q] = push_rec;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (wr_en && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !wr_en) begin
      count_d = count_q - 1'b1;
    end

    if (fire && out_q.denied && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // State registers; reset drops everything buffered or presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) storage_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) storage_q[i] <= storage_d[i];
    end
  end

  assign resp_rdy  = (count_q < CNT_FULL);
  assign d_valid   = (state_q == ST_HOLD);
  assign d_opcode  = out_q.opcode;
  assign d_param   = 2'd0;
  assign d_size    = out_q.size;
  assign d_source  = out_q.source;
  assign d_sink    = 1'(SINK_ID);
  assign d_denied  = out_q.denied;
  assign d_corrupt = out_q.corrupt;
  assign d_data    = out_q.data;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_tl_d_resp_fifo.sv
// Self-checking bench for tl_d_resp_fifo: a table of opcode-mapping vectors
// plus directed sequences for backpressure, capacity, wrap, reset and
// error-counter saturation, all checked against a queue-based model.
module tb_tl_d_resp_fifo;

  localparam int FIFO_DEPTH = 6;
  localparam int DATA_W     = 32;
  localparam int SRC_W      = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              resp_push;
  logic [2:0]        resp_opcode;
  logic [2:0]        resp_size;
  logic [SRC_W-1:0]  resp_source;
  logic              resp_denied;
  logic [DATA_W-1:0] resp_data;
  logic              resp_rdy;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_sink;
  logic              d_denied;
  logic              d_corrupt;
  logic [DATA_W-1:0] d_data;
  logic [7:0]        err_count;

  tl_d_resp_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_W(DATA_W), .SRC_W(SRC_W), .SINK_ID(0)) dut (
    .clk(clk), .rst_n(rst_n), .resp_push(resp_push), .resp_opcode(resp_opcode),
    .resp_size(resp_size), .resp_source(resp_source), .resp_denied(resp_denied),
    .resp_data(resp_data), .resp_rdy(resp_rdy), .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_corrupt(d_corrupt), .d_data(d_data),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [3:0]  source;
    logic        denied;
    logic        corrupt;
    logic [31:0] data;
  } rec_t;

  typedef struct {
    logic [2:0]  in_opcode;
    logic        in_denied;
    logic [3:0]  in_source;
    logic [2:0]  in_size;
    logic [31:0] in_data;
    logic [2:0]  exp_opcode;
    logic        exp_denied;
    logic        exp_corrupt;
    logic [31:0] exp_data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  logic [7:0] err_exp = 8'd0;
  logic accepted;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic rec_t map_rec(input logic [2:0] op, input logic [2:0] sz,
                                   input logic [3:0] src, input logic den, input logic [31:0] dat);
    rec_t r;
    r.size = sz; r.source = src; r.corrupt = 1'b0; r.data = 32'd0;
    if (op == 3'd4) begin
      r.opcode = 3'd1; r.denied = den; r.corrupt = den; r.data = den ? 32'd0 : dat;
    end else if (op == 3'd0 || op == 3'd1) begin
      r.opcode = 3'd0; r.denied = den;
    end else begin
      r.opcode = 3'd0; r.denied = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [63:0] pack_rec(input rec_t r);
    return {17'd0, 2'd0, 1'b0, r.opcode, r.size, r.source, r.denied, r.corrupt, r.data};
  endfunction

  // One clock cycle: check the DUT against the model, then advance both
  task automatic apply_stimulus();
    logic exp_rdy;
    int   fifo_cnt;
    fifo_cnt = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
    exp_rdy  = (fifo_cnt < FIFO_DEPTH);
    check_output("d_valid", 64'(d_valid), 64'(exp_q.size() > 0));
    check_output("resp_rdy", 64'(resp_rdy), 64'(exp_rdy));
    check_output("err_count", 64'(err_count), 64'(err_exp));
    if (exp_q.size() > 0)
      check_output("d_fields",
        {17'd0, d_param, d_sink, d_opcode, d_size, d_source, d_denied, d_corrupt, d_data},
        pack_rec(exp_q[0]));
    if (exp_q.size() > 0 && d_ready) begin
      if (exp_q[0].denied && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
      void'(exp_q.pop_front());
    end
    accepted = resp_push && exp_rdy;
    if (accepted) exp_q.push_back(map_rec(resp_opcode, resp_size, resp_source, resp_denied, resp_data));
    @(posedge clk); #1;
  endtask

  task automatic set_push(input logic en, input logic [2:0] op, input logic [3:0] src,
                          input logic den, input logic [31:0] dat);
    resp_push = en; resp_opcode = op; resp_source = src; resp_denied = den;
    resp_data = dat; resp_size = 3'(src % 4);
  endtask

  task automatic drain();
    d_ready = 1'b1;
    set_push(1'b0, 3'd0, 4'd0, 1'b0, 32'd0);
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) apply_stimulus();
    check_output("drain_done", 64'(exp_q.size()), 64'd0);
    apply_stimulus();
    d_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{3'd4, 1'b0, 4'd3,  3'd2, 32'hDEADBEEF, 3'd1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{3'd0, 1'b0, 4'd1,  3'd2, 32'h12345678, 3'd0, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{3'd1, 1'b0, 4'd2,  3'd1, 32'h0BADF00D, 3'd0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{3'd4, 1'b1, 4'd5,  3'd2, 32'hAAAA5555, 3'd1, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{3'd2, 1'b0, 4'd6,  3'd0, 32'h11111111, 3'd0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{3'd7, 1'b0, 4'd15, 3'd3, 32'h22222222, 3'd0, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{3'd0, 1'b1, 4'd9,  3'd2, 32'h33333333, 3'd0, 1'b1, 1'b0, 32'h0};

    rst_n = 1'b0; d_ready = 1'b0;
    set_push(1'b0, 3'd0, 4'd0, 1'b0, 32'd0);
    #12;
    check_output("reset_d_valid", 64'(d_valid), 64'd0);
    check_output("reset_err_count", 64'(err_count), 64'd0);
    check_output("reset_d_data", 64'(d_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("reset_resp_rdy", 64'(resp_rdy), 64'd1);

    // Opcode mapping table: push each vector, inspect, then accept it
    foreach (vecs[i]) begin
      d_ready = 1'b0;
      set_push(1'b1, vecs[i].in_opcode, vecs[i].in_source, vecs[i].in_denied, vecs[i].in_data);
      resp_size = vecs[i].in_size;
      apply_stimulus();
      set_push(1'b0, 3'd0, 4'd0, 1'b0, 32'd0);
      check_output("vec_valid", 64'(d_valid), 64'd1);
      check_output("vec_opcode", 64'(d_opcode), 64'(vecs[i].exp_opcode));
      check_output("vec_denied", 64'(d_denied), 64'(vecs[i].exp_denied));
      check_output("vec_corrupt", 64'(d_corrupt), 64'(vecs[i].exp_corrupt));
      check_output("vec_data", 64'(d_data), 64'(vecs[i].exp_data));
      check_output("vec_source", 64'(d_source), 64'(vecs[i].in_source));
      check_output("vec_size", 64'(d_size), 64'(vecs[i].in_size));
      d_ready = 1'b1;
      apply_stimulus();
      check_output("vec_single_beat", 64'(d_valid), 64'd0);
    end
    check_output("err_after_table", 64'(err_count), 64'd4);

    // Fill under backpressure: seven accepted, eighth ignored, head frozen
    d_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_push(1'b1, 3'd0, 4'(i), 1'b0, 32'(i));
      apply_stimulus();
    end
    set_push(1'b0, 3'd0, 4'd0, 1'b0, 32'd0);
    check_output("full_resp_rdy", 64'(resp_rdy), 64'd0);
    check_output("frozen_source", 64'(d_source), 64'd0);
    check_output("full_depth", 64'(exp_q.size()), 64'(FIFO_DEPTH + 1));
    drain();

    // Full FIFO with a pop and a push in the same cycle: push is rejected
    for (int i = 0; i < 7; i++) begin
      set_push(1'b1, 3'd1, 4'(i + 8), 1'b0, 32'd0);
      apply_stimulus();
    end
    d_ready = 1'b1;
    set_push(1'b1, 3'd4, 4'd14, 1'b0, 32'hCAFE);
    apply_stimulus();
    check_output("full_pop_push_rejected", 64'(accepted), 64'd0);
    check_output("rdy_after_pop", 64'(resp_rdy), 64'd1);
    drain();

    // Stream 20 records with d_ready toggling; order must survive pointer wrap
    for (int i = 0, n = 0; i < 20 && n < 200; n++) begin
      d_ready = n[0];
      set_push(1'b1, (i % 3 == 0) ? 3'd4 : 3'd0, 4'(i), 1'b0, 32'(32'h100 + i));
      apply_stimulus();
      if (accepted) i++;
    end
    drain();

    // Asynchronous reset with a response on the bus
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 3'd3, 4'(i), 1'b0, 32'd0);
      apply_stimulus();
    end
    set_push(1'b0, 3'd0, 4'd0, 1'b0, 32'd0);
    d_ready = 1'b1;
    apply_stimulus();
    check_output("pre_reset_valid", 64'(d_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_valid", 64'(d_valid), 64'd0);
    check_output("async_reset_err", 64'(err_count), 64'd0);
    exp_q.delete();
    err_exp = 8'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    d_ready = 1'b0;
    apply_stimulus();
    check_output("post_reset_rdy", 64'(resp_rdy), 64'd1);

    // 260 denied responses: counter saturates
    d_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      set_push(1'b1, 3'd2, 4'(i), 1'b0, 32'd0);
      apply_stimulus();
    end
    drain();
    check_output("err_saturated", 64'(err_count), 64'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
